uart_rx_fifo: RTL and testbench

Buffered UART receiver between the `rx` pin and the SoC bus decoder's UART read path. It oversamples the asynchronous `rx` line, deserialises 8N1 frames and pushes each byte into a small FIFO. The bus decoder pops bytes with a one-cycle `re` pulse. `so` reads all-ones when nothing is buffered, so software polls "data available" as `so != ~0`.

---
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Pin and bus-decoder side of the buffered UART receiver.
// The slave modport is the receiver. The master modport is whatever drives rx, re and clr.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  logic                     rx;
  logic                     re;
  logic                     clr;
  logic [31:0]              so;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overrun;
  logic                     frame_err;
  logic                     parity_err;

  modport master (
    output rx, re, clr,
    input  so, empty, full, count, overrun, frame_err, parity_err
  );

  modport slave (
    input  rx, re, clr,
    output so, empty, full, count, overrun, frame_err, parity_err
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a DEPTH-entry FIFO. A byte appears on so one cycle after its stop-bit sample.
// There is no backpressure: a byte arriving at a full FIFO is dropped and sets overrun. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LD   = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LD  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic          rx_meta, rx_s;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, sh_n;
  logic          expire;
  logic          push, set_fe;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_bad_n, set_pe;
  logic          parity_err;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, do_push, do_pop, overflow;
  logic          overrun, frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // A load of L expires exactly L cycles later, so a half-bit load lands mid start bit.
  assign expire = (cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= sh_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = (cnt != '0) ? cnt - CNT_ONE : '0;
    bit_idx_n = bit_idx;
    sh_n      = shreg;
    push      = 1'b0;
    set_fe    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    set_pe    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_LD;
          state_n = S_START;
        end
      end
      S_START: begin
        if (expire) begin
          if (!rx_s) begin
            state_n   = S_DATA;
            cnt_n     = BIT_LD;
            bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_n = 1'b0;
`endif
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (expire) begin
          sh_n      = {rx_s, shreg[7:1]};
          cnt_n     = BIT_LD;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (expire) begin
          cnt_n   = BIT_LD;
          state_n = S_STOP;
          if (rx_s != ^shreg) begin
            par_bad_n = 1'b1;
            set_pe    = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (expire) begin
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad;
`else
            push = 1'b1;
`endif
            state_n = S_IDLE;
          end else begin
            set_fe  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign empty    = (count == '0);
  assign full     = (count == OCC_FULL);
  assign do_pop   = bus.re && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun    <= overflow | (overrun & ~bus.clr);
      frame_err  <= set_fe | (frame_err & ~bus.clr);
`ifdef UART_RX_PARITY_EN
      parity_err <= set_pe | (parity_err & ~bus.clr);
`endif
    end
  end

  assign bus.so        = empty ? 32'hFFFF_FFFF : {24'h0, mem[rd_ptr]};
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count;
  assign bus.overrun   = overrun;
  assign bus.frame_err = frame_err;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bytes queued as frames are sent, compared as they are popped.
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Two sync flops plus the IDLE detect edge, then a half-bit wait, then whole bits up to the stop bit.
  localparam int STOP_LAT = 3 + CPB / 2 + CPB * (FRAME_BITS - 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  logic [7:0] q[$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      tick(CPB);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = (^d) ^ par_flip;
    tick(CPB);
`endif
    bus.rx = stop_bit;
    tick(CPB);
  endtask

  task automatic pulse_re;
    bus.re = 1'b1;
    tick(1);
    bus.re = 1'b0;
  endtask

  task automatic pulse_clr;
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    tick(1);
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (bus.so !== 32'hFFFF_FFFF) $display("FAIL reset_so: got %h want ffffffff", bus.so); else passed++;
    checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty); else passed++;
    checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else passed++;
    checks++; if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun); else passed++;
    checks++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); else passed++;
    checks++; if (bus.parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b want 0", bus.parity_err); else passed++;
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single;
    int c0;
    int seen;
    logic [7:0] exp;
    c0 = cyc;
    seen = -1;
    q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < STOP_LAT + 20 && seen < 0; i++) begin
          tick(1);
          if (bus.count != 3'd0) seen = cyc - c0;
        end
      end
    join
    checks++; if (seen != STOP_LAT) $display("FAIL single_latency: got %0d cycles want %0d", seen, STOP_LAT); else passed++;
    checks++; if (bus.count !== 3'd1) $display("FAIL single_count: got %0d want 1", bus.count); else passed++;
    exp = q.pop_front();
    checks++; if (bus.so !== {24'h0, exp}) $display("FAIL single_so: got %h want %h", bus.so, {24'h0, exp}); else passed++;
    pulse_re();
    checks++; if (bus.so !== 32'hFFFF_FFFF) $display("FAIL single_so_after_pop: got %h want ffffffff", bus.so); else passed++;
    checks++; if (bus.empty !== 1'b1) $display("FAIL single_empty: got %b want 1", bus.empty); else passed++;
    // re while empty is ignored.
    pulse_re();
    checks++; if (bus.count !== 3'd0) $display("FAIL empty_pop_count: got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_overrun;
    logic [7:0] exp;
    for (int d = 1; d <= 5; d++) begin
      send_frame(8'(d), 1'b1);
      if (d <= DEPTH) q.push_back(8'(d));
      if (d == 3) begin
        checks++; if (bus.full !== 1'b0) $display("FAIL ovr_full_at3: got %b want 0", bus.full); else passed++;
      end
      if (d == 4) begin
        checks++; if (bus.full !== 1'b1) $display("FAIL ovr_full_at4: got %b want 1", bus.full); else passed++;
        checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_early: got %b want 0", bus.overrun); else passed++;
      end
    end
    checks++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", bus.overrun); else passed++;
    checks++; if (bus.count !== 3'd4) $display("FAIL ovr_count: got %0d want 4", bus.count); else passed++;
    while (q.size() > 0) begin
      exp = q.pop_front();
      checks++; if (bus.so !== {24'h0, exp}) $display("FAIL ovr_pop: got %h want %h", bus.so, {24'h0, exp}); else passed++;
      pulse_re();
    end
    checks++; if (bus.empty !== 1'b1) $display("FAIL ovr_drained: got %b want 1", bus.empty); else passed++;
    pulse_clr();
    checks++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clr: got %b want 0", bus.overrun); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    for (int d = 1; d <= 4; d++) begin
      send_frame(8'(d), 1'b1);
      q.push_back(8'(d));
    end
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(STOP_LAT - 1);
        exp = q.pop_front();
        checks++; if (bus.so !== {24'h0, exp}) $display("FAIL b2b_head: got %h want %h", bus.so, {24'h0, exp}); else passed++;
        bus.re = 1'b1;
        tick(1);
        bus.re = 1'b0;
      end
    join
    q.push_back(8'h05);
    checks++; if (bus.count !== 3'd4) $display("FAIL b2b_count: got %0d want 4", bus.count); else passed++;
    checks++; if (bus.overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", bus.overrun); else passed++;
    while (q.size() > 0) begin
      exp = q.pop_front();
      checks++; if (bus.so !== {24'h0, exp}) $display("FAIL b2b_pop: got %h want %h", bus.so, {24'h0, exp}); else passed++;
      pulse_re();
    end
  endtask

  task automatic test_glitch;
    logic [7:0] exp;
    bus.rx = 1'b0;
    tick(5);
    bus.rx = 1'b1;
    tick(3 * CPB);
    checks++; if (bus.count !== 3'd0) $display("FAIL glitch_count: got %0d want 0", bus.count); else passed++;
    checks++; if (bus.frame_err !== 1'b0) $display("FAIL glitch_frame_err: got %b want 0", bus.frame_err); else passed++;
    send_frame(8'h3C, 1'b1);
    q.push_back(8'h3C);
    exp = q.pop_front();
    checks++; if (bus.so !== {24'h0, exp}) $display("FAIL glitch_next: got %h want %h", bus.so, {24'h0, exp}); else passed++;
    pulse_re();
  endtask

  task automatic test_frame_err;
    logic [7:0] exp;
    send_frame(8'h55, 1'b0);
    tick(100);
    checks++; if (bus.frame_err !== 1'b1) $display("FAIL ferr_set: got %b want 1", bus.frame_err); else passed++;
    checks++; if (bus.count !== 3'd0) $display("FAIL ferr_count: got %0d want 0", bus.count); else passed++;
    bus.rx = 1'b1;
    tick(5);
    send_frame(8'h66, 1'b1);
    q.push_back(8'h66);
    exp = q.pop_front();
    checks++; if (bus.so !== {24'h0, exp}) $display("FAIL ferr_next: got %h want %h", bus.so, {24'h0, exp}); else passed++;
    pulse_re();
    pulse_clr();
    checks++; if (bus.frame_err !== 1'b0) $display("FAIL ferr_clr: got %b want 0", bus.frame_err); else passed++;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    logic [7:0] exp;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    q.push_back(8'h11);
    q.push_back(8'h22);
    checks++; if (bus.count !== 3'd2) $display("FAIL mid_count_before: got %0d want 2", bus.count); else passed++;
    d = 8'hC3;
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      bus.rx = d[i];
      tick(CPB);
    end
    bus.rx = d[3];
    tick(CPB / 2);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.empty !== 1'b1) $display("FAIL mid_empty: got %b want 1", bus.empty); else passed++;
    checks++; if (bus.so !== 32'hFFFF_FFFF) $display("FAIL mid_so: got %h want ffffffff", bus.so); else passed++;
    q.delete();
    bus.rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h81, 1'b1);
    par_flip = 1'b0;
    checks++; if (bus.parity_err !== 1'b1) $display("FAIL mid_parity_err: got %b want 1", bus.parity_err); else passed++;
    checks++; if (bus.count !== 3'd0) $display("FAIL mid_parity_count: got %0d want 0", bus.count); else passed++;
    pulse_clr();
    checks++; if (bus.parity_err !== 1'b0) $display("FAIL mid_parity_clr: got %b want 0", bus.parity_err); else passed++;
`else
    send_frame(8'h81, 1'b1);
    q.push_back(8'h81);
    exp = q.pop_front();
    checks++; if (bus.so !== {24'h0, exp}) $display("FAIL mid_next: got %h want %h", bus.so, {24'h0, exp}); else passed++;
    pulse_re();
    checks++; if (bus.parity_err !== 1'b0) $display("FAIL mid_parity_tied: got %b want 0", bus.parity_err); else passed++;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx  = 1'b1;
    bus.re  = 1'b0;
    bus.clr = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
